sdm_sample_sched: RTL and testbench



---
 rtl/sdm_pkg.sv | 13 +
 rtl/sdm_sample_fifo.sv | 67 ++++++
 rtl/sdm_sample_sched.sv | 145 ++++++++++++++
 tb/tb_sdm_sample_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// Types and default widths shared by the sample scheduler and the modulator wrapper.
package sdm_pkg;

  localparam int SDM_N     = 16;
  localparam int SDM_OSR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sdm_sample_fifo.sv
// Small synchronous sample FIFO with flush; the head word is presented combinationally.
module sdm_sample_fifo #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [N-1:0]             i_wdata,
  output logic [N-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  // Storage is not reset: contents are only observable through a non-empty level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sdm_sample_sched.sv
// Holds each buffered PCM sample on the modulator input for P clocks.
//   state | meaning
//   IDLE  | disabled, din forced to 0, FIFO flushed
//   PRIME | waiting for PRIME_LVL samples before (re)starting
//   RUN   | counting the hold period, loading the next sample at terminal count
module sdm_sample_sched
  import sdm_pkg::*;
#(
  parameter int N         = SDM_N,
  parameter int OSR_W     = SDM_OSR_W,
  parameter int DEPTH     = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     enable,
  input  logic [OSR_W-1:0]         osr,
  input  logic                     s_valid,
  input  logic [N-1:0]             s_data,
  output logic                     s_ready,
  output logic [N-1:0]             din,
  output logic                     sample_stb,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun,
  input  logic                     clr_status
);

  localparam int LW = $clog2(DEPTH) + 1;

  sched_state_t     r_state;
  logic [OSR_W-1:0] r_cnt;
  logic [OSR_W-1:0] r_p;
  logic [N-1:0]     r_din;
  logic             r_stb;
  logic             r_underrun;

  logic             w_push;
  logic             w_load;
  logic             w_flush;
  logic             w_tc;
  logic             w_prime_ok;
  logic             w_underrun_evt;
  logic [N-1:0]     w_head;
  logic [LW-1:0]    w_level;
  logic             w_full;
  logic             w_empty;
  logic [OSR_W-1:0] w_p_next;

  assign w_flush  = !enable;
  assign s_ready  = enable && !w_full;
  assign w_push   = s_valid && s_ready;
  assign w_tc     = (r_cnt == r_p - OSR_W'(1));
  assign w_p_next = (osr == '0) ? OSR_W'(1) : osr;

  // Threshold uses the registered level, so a push in the same cycle does not count.
  assign w_prime_ok = (w_level >= LW'(PRIME_LVL));

  assign w_load = enable &&
                  (((r_state == PRIME) && w_prime_ok) ||
                   ((r_state == RUN) && w_tc && !w_empty));

  assign w_underrun_evt = enable && (r_state == RUN) && w_tc && w_empty;

  sdm_sample_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .i_push  (w_push),
    .i_pop   (w_load),
    .i_flush (w_flush),
    .i_wdata (s_data),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= OSR_W'(1);
      r_din   <= '0;
      r_stb   <= 1'b0;
    end else if (!enable) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_din   <= '0;
      r_stb   <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= PRIME;
        end
        PRIME: begin
          if (w_prime_ok) begin
            r_din   <= w_head;
            r_stb   <= 1'b1;
            r_cnt   <= '0;
            r_p     <= w_p_next;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_tc) begin
            r_cnt <= '0;
            if (!w_empty) begin
              r_din <= w_head;
              r_stb <= 1'b1;
              r_p   <= w_p_next;
            end else begin
              // Starved: keep the last sample on the modulator and re-prime.
              r_state <= PRIME;
            end
          end else begin
            r_cnt <= r_cnt + OSR_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // A new underrun in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_evt) begin
      r_underrun <= 1'b1;
    end else if (clr_status) begin
      r_underrun <= 1'b0;
    end
  end

  assign din        = r_din;
  assign sample_stb = r_stb;
  assign fifo_level = w_level;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_sdm_sample_sched.sv
// Directed bench for sdm_sample_sched: instance A primes at 2 samples, instance B at 1.
module tb_sdm_sample_sched;
  import sdm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;

  logic        a_enable, a_s_valid, a_s_ready, a_stb, a_underrun, a_clr;
  logic [7:0]  a_osr;
  logic [15:0] a_s_data, a_din;
  logic [2:0]  a_level;

  logic        b_enable, b_s_valid, b_s_ready, b_stb, b_underrun, b_clr;
  logic [7:0]  b_osr;
  logic [15:0] b_s_data, b_din;
  logic [2:0]  b_level;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] v, exp_v;
  int          last_stb, n_stb;
  logic        push_b;

  sdm_sample_sched #(.N(16), .OSR_W(8), .DEPTH(4), .PRIME_LVL(2)) u_a (
    .clk(clk), .areset(areset), .enable(a_enable), .osr(a_osr),
    .s_valid(a_s_valid), .s_data(a_s_data), .s_ready(a_s_ready),
    .din(a_din), .sample_stb(a_stb), .fifo_level(a_level),
    .underrun(a_underrun), .clr_status(a_clr)
  );

  sdm_sample_sched #(.N(16), .OSR_W(8), .DEPTH(4), .PRIME_LVL(1)) u_b (
    .clk(clk), .areset(areset), .enable(b_enable), .osr(b_osr),
    .s_valid(b_s_valid), .s_data(b_s_data), .s_ready(b_s_ready),
    .din(b_din), .sample_stb(b_stb), .fifo_level(b_level),
    .underrun(b_underrun), .clr_status(b_clr)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_a(input int n, input logic [15:0] e);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("hold_stb", 16'(a_stb), 16'd0);
      chk("hold_din", a_din, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset    = 1'b0;
    a_enable  = 1'b0; a_osr = 8'd4; a_s_valid = 1'b0; a_s_data = 16'd0; a_clr = 1'b0;
    b_enable  = 1'b0; b_osr = 8'd3; b_s_valid = 1'b0; b_s_data = 16'd0; b_clr = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_din",   a_din,                 16'd0);
    chk("rst_stb",   16'(a_stb),            16'd0);
    chk("rst_unr",   16'(a_underrun),       16'd0);
    chk("rst_lvl",   16'(a_level),          16'd0);
    chk("rst_state", 16'(u_a.r_state),      16'(IDLE));
    chk("rst_b_din", b_din,                 16'd0);
    areset = 1'b1;

    // 1: cadence, osr=4
    a_enable = 1'b1; a_s_valid = 1'b1; a_s_data = 16'd100;
    tick();
    chk("t1_lvl1", 16'(a_level), 16'd1);
    chk("t1_prime", 16'(u_a.r_state), 16'(PRIME));
    a_s_data = 16'd200;
    tick();
    chk("t1_lvl2", 16'(a_level), 16'd2);
    chk("t1_nostb", 16'(a_stb), 16'd0);
    a_s_data = 16'(-300);
    tick();
    chk("t1_din0", a_din, 16'd100);
    chk("t1_stb0", 16'(a_stb), 16'd1);
    chk("t1_lvl3", 16'(a_level), 16'd2);
    a_s_valid = 1'b0;
    hold_a(3, 16'd100);
    tick();
    chk("t1_din1", a_din, 16'd200);
    chk("t1_stb1", 16'(a_stb), 16'd1);
    hold_a(3, 16'd200);
    tick();
    chk("t1_din2", a_din, 16'(-300));
    chk("t1_stb2", 16'(a_stb), 16'd1);
    chk("t1_lvl0", 16'(a_level), 16'd0);
    hold_a(3, 16'(-300));
    chk("t1_unr_pre", 16'(a_underrun), 16'd0);
    tick();
    chk("t1_unr", 16'(a_underrun), 16'd1);
    chk("t1_unr_stb", 16'(a_stb), 16'd0);
    chk("t1_unr_din", a_din, 16'(-300));
    chk("t1_unr_st", 16'(u_a.r_state), 16'(PRIME));
    a_clr = 1'b1;
    tick();
    chk("t1_clr", 16'(a_underrun), 16'd0);
    a_clr = 1'b0;

    // 2: backpressure, osr=8, continuous valid with incrementing data
    a_osr = 8'd8; a_s_valid = 1'b1;
    v = 16'h0A00; exp_v = 16'h0A00; a_s_data = v;
    last_stb = 0; n_stb = 0;
    for (int cyc = 1; cyc <= 44; cyc++) begin
      push_b = a_s_valid && a_s_ready;
      tick();
      if (push_b) v = v + 16'd1;
      a_s_data = v;
      if (cyc >= 39) a_s_valid = 1'b0;
      if (cyc == 5) begin
        chk("t2_full_lvl", 16'(a_level), 16'd4);
        chk("t2_full_rdy", 16'(a_s_ready), 16'd0);
      end
      if (cyc == 11) chk("t2_lvl11", 16'(a_level), 16'd3);
      if (cyc == 44) chk("t2_lvl44", 16'(a_level), 16'd3);
      if (a_stb) begin
        if (last_stb != 0) chk("t2_gap", 16'(cyc - last_stb), 16'd8);
        chk("t2_din", a_din, exp_v);
        exp_v = exp_v + 16'd1;
        last_stb = cyc;
        n_stb++;
      end
    end
    chk("t2_nstb", 16'(n_stb), 16'd6);

    // 5: enable drop mid-hold with level=3
    a_enable = 1'b0; a_s_valid = 1'b1; a_s_data = 16'h7777;
    #1;
    chk("t5_rdy", 16'(a_s_ready), 16'd0);
    tick();
    chk("t5_din", a_din, 16'd0);
    chk("t5_lvl", 16'(a_level), 16'd0);
    chk("t5_stb", 16'(a_stb), 16'd0);
    chk("t5_idle", 16'(u_a.r_state), 16'(IDLE));
    a_s_valid = 1'b0; a_enable = 1'b1;
    tick();
    chk("t5_prime", 16'(u_a.r_state), 16'(PRIME));
    repeat (3) tick();
    chk("t5_wait_st", 16'(u_a.r_state), 16'(PRIME));
    chk("t5_wait_din", a_din, 16'd0);
    chk("t5_wait_stb", 16'(a_stb), 16'd0);

    // 4a: osr=0 behaves as P=1
    a_osr = 8'd0; a_s_valid = 1'b1; a_s_data = 16'd1;
    tick();
    a_s_data = 16'd2;
    tick();
    a_s_data = 16'd3;
    tick();
    chk("t4_din1", a_din, 16'd1);
    chk("t4_stb1", 16'(a_stb), 16'd1);
    a_s_data = 16'd4;
    tick();
    chk("t4_din2", a_din, 16'd2);
    chk("t4_stb2", 16'(a_stb), 16'd1);
    a_s_valid = 1'b0;
    tick();
    chk("t4_din3", a_din, 16'd3);
    chk("t4_stb3", 16'(a_stb), 16'd1);
    tick();
    chk("t4_din4", a_din, 16'd4);
    chk("t4_lvl", 16'(a_level), 16'd0);
    chk("t4_unr_pre", 16'(a_underrun), 16'd0);
    tick();
    chk("t4_unr", 16'(a_underrun), 16'd1);
    chk("t4_unr_stb", 16'(a_stb), 16'd0);
    chk("t4_unr_din", a_din, 16'd4);

    // 4b: osr change mid-hold takes effect only after the next load
    a_osr = 8'd3; a_s_valid = 1'b1; a_s_data = 16'd5;
    tick();
    a_s_data = 16'd6;
    tick();
    a_s_data = 16'd7;
    tick();
    chk("t4b_din5", a_din, 16'd5);
    chk("t4b_stb5", 16'(a_stb), 16'd1);
    a_s_valid = 1'b0; a_osr = 8'd5;
    hold_a(2, 16'd5);
    tick();
    chk("t4b_din6", a_din, 16'd6);
    chk("t4b_stb6", 16'(a_stb), 16'd1);
    hold_a(4, 16'd6);
    tick();
    chk("t4b_din7", a_din, 16'd7);
    chk("t4b_stb7", 16'(a_stb), 16'd1);

    // 6: asynchronous reset between clock edges
    a_s_valid = 1'b1; a_s_data = 16'd8;
    tick();
    a_s_valid = 1'b0;
    chk("t6_pre_lvl", 16'(a_level), 16'd1);
    chk("t6_pre_unr", 16'(a_underrun), 16'd1);
    chk("t6_pre_din", a_din, 16'd7);
    #3;
    areset = 1'b0;
    #1;
    chk("t6_din", a_din, 16'd0);
    chk("t6_unr", 16'(a_underrun), 16'd0);
    chk("t6_lvl", 16'(a_level), 16'd0);
    chk("t6_state", 16'(u_a.r_state), 16'(IDLE));
    #2;
    areset = 1'b1;

    // 3: underrun and recovery on the PRIME_LVL=1 instance, osr=3
    b_enable = 1'b1; b_osr = 8'd3; b_s_valid = 1'b1; b_s_data = 16'd55;
    tick();
    b_s_valid = 1'b0;
    chk("t3_lvl1", 16'(b_level), 16'd1);
    tick();
    chk("t3_din55", b_din, 16'd55);
    chk("t3_stb55", 16'(b_stb), 16'd1);
    repeat (2) tick();
    chk("t3_unr_pre", 16'(b_underrun), 16'd0);
    chk("t3_nostb", 16'(b_stb), 16'd0);
    tick();
    chk("t3_unr", 16'(b_underrun), 16'd1);
    chk("t3_unr_st", 16'(u_b.r_state), 16'(PRIME));
    chk("t3_unr_din", b_din, 16'd55);
    b_s_valid = 1'b1; b_s_data = 16'd7;
    tick();
    b_s_valid = 1'b0;
    chk("t3_lat1_din", b_din, 16'd55);
    chk("t3_lat1_stb", 16'(b_stb), 16'd0);
    tick();
    chk("t3_din7", b_din, 16'd7);
    chk("t3_stb7", 16'(b_stb), 16'd1);
    repeat (2) tick();
    b_clr = 1'b1;
    tick();
    chk("t3_setwins", 16'(b_underrun), 16'd1);
    chk("t3_prime2", 16'(u_b.r_state), 16'(PRIME));
    tick();
    chk("t3_clr", 16'(b_underrun), 16'd0);
    b_clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
